sar_cdac_ctrl: RTL and testbench
================================

SAR_CDAC_CTRL -- requirements
Module: sar_cdac_ctrl

Interface
REQ-001 Parameter NBIT, default 11: conversion resolution and CDAC switch count; legal range 4..16.
REQ-002 Parameter SAMPLE_CYC, default 4: sampling-phase length in clock cycles; legal range 1..255.
REQ-003 Parameter CMP_TMO, default 16: comparator-ready timeout in cycles, used only under SAR_CMP_TMO_EN; legal range 2..255.
REQ-004 CLK  input  1  sole clock; all logic on rising edge.
REQ-005 RST  input  1  reset; one clock, reset is synchronous and active-high.
REQ-006 START  input  1  conversion request, sampled only in IDLE.
REQ-007 CMP_RDY  input  1  comparator decision valid.
REQ-008 CMP_OUT  input  1  comparator decision; 1 = keep trial bit.
REQ-009 SMP  output  1  sampling switch enable, high during SAMPLE.
REQ-010 CMP_EN  output  1  one-cycle comparator trigger pulse.
REQ-011 SW  output  NBIT  CDAC bottom-plate switch drive; SW[k] has weight 2^k.
REQ-012 DOUT  output  NBIT  last conversion result, held until the next DONE.
REQ-013 DVALID  output  1  one-cycle pulse, DOUT updated this cycle.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 ERR  output  1  sticky comparator-timeout flag.

Function
REQ-016 FSM states: IDLE, SAMPLE, TRIAL, WAIT, DONE; registered outputs only.
REQ-017 IDLE: START=1 -> SAMPLE next cycle; SW cleared to 0; ERR cleared to 0; otherwise remain.
REQ-018 SAMPLE: SMP=1 for exactly SAMPLE_CYC cycles, SW=0; then TRIAL with bit index k=NBIT-1.
REQ-019 TRIAL (one cycle): SW[k] set to 1, CMP_EN=1; -> WAIT.
REQ-020 WAIT: CMP_RDY sampled from the cycle after CMP_EN; on CMP_RDY=1, SW[k]<=CMP_OUT; if k=0 -> DONE, else k<=k-1 and -> TRIAL.
REQ-021 CMP_RDY asserted in TRIAL or while in SAMPLE/IDLE/DONE is ignored.
REQ-022 DONE (one cycle): DOUT<=SW, DVALID=1; -> IDLE; SW holds the final code until the next START.
REQ-023 START while BUSY is ignored; no queuing.
REQ-024 Latency START-to-DVALID with CMP_RDY on first WAIT cycle: exactly SAMPLE_CYC + 2*NBIT + 2 cycles.
REQ-025 Bits already resolved never change after their WAIT decision; bits below k stay 0 until their TRIAL.
REQ-026 CMP_EN never high in two consecutive cycles; SMP and CMP_EN never high together.

Reset
REQ-027 RST=1 at any edge, including mid-conversion: state->IDLE, SW=0, DOUT=0, SMP=0, CMP_EN=0, DVALID=0, BUSY=0, ERR=0, bit index and counters cleared.
REQ-028 RST takes priority over START in the same cycle.

Configuration
REQ-029 Macro SAR_CMP_TMO_EN defined: counter runs in WAIT; if CMP_RDY not seen within CMP_TMO cycles after CMP_EN, SW[k]<=0, ERR<=1, FSM proceeds as if CMP_RDY=1 with CMP_OUT=0.
REQ-030 Macro undefined: WAIT holds indefinitely until CMP_RDY; ERR tied to 0; no timeout counter synthesised.

Verification
REQ-031 NBIT=11, SAMPLE_CYC=4, comparator model of input 1234 (CMP_OUT = trial code <= 1234, CMP_RDY next cycle) -> DOUT=1234, DVALID at cycle 4+22+2=28 after START.
REQ-032 Inputs 0 and 2047 -> DOUT=0 and DOUT=2047; SW trial sequence 1024,512,... observed on each TRIAL.
REQ-033 CMP_RDY delayed 5 cycles every bit -> same DOUT, latency 4+11*6+2=72; CMP_EN exactly 11 pulses.
REQ-034 RST asserted on the 3rd WAIT -> next cycle all outputs 0, BUSY=0; a fresh START converts correctly.
REQ-035 START pulsed during WAIT -> ignored, exactly one DVALID per accepted START.
REQ-036 SAR_CMP_TMO_EN, CMP_TMO=16, CMP_RDY withheld on MSB -> SW[10]=0, ERR=1 after 16 cycles, conversion completes; ERR clears on next START.

Source files
------------

// File: rtl/sar_cdac_ctrl.sv
// rtl/sar_cdac_ctrl.sv - SAR ADC capacitive-DAC switch controller (optional SAR_CMP_TMO_EN comparator timeout)
module sar_cdac_ctrl #(
    parameter int NBIT       = 11,
    parameter int SAMPLE_CYC = 4,
    parameter int CMP_TMO    = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            CMP_RDY,
    input  logic            CMP_OUT,
    output logic            SMP,
    output logic            CMP_EN,
    output logic [NBIT-1:0] SW,
    output logic [NBIT-1:0] DOUT,
    output logic            DVALID,
    output logic            BUSY,
    output logic            ERR
);

    localparam int KW = $clog2(NBIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_TRIAL  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Elaboration-time parameter range checks
    if (NBIT < 4 || NBIT > 16) begin : g_bad_nbit
        $error("sar_cdac_ctrl: NBIT must be 4..16");
    end
    if (SAMPLE_CYC < 1 || SAMPLE_CYC > 255) begin : g_bad_smp
        $error("sar_cdac_ctrl: SAMPLE_CYC must be 1..255");
    end
    if (CMP_TMO < 2 || CMP_TMO > 255) begin : g_bad_tmo
        $error("sar_cdac_ctrl: CMP_TMO must be 2..255");
    end

    logic [2:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [KW-1:0]   k_q, k_d;
    logic [NBIT-1:0] sw_q, sw_d;
    logic [NBIT-1:0] dout_q, dout_d;
    logic            smp_q, smp_d;
    logic            cmp_en_q, cmp_en_d;
    logic            dvalid_q, dvalid_d;
    logic            busy_q, busy_d;
    logic            timeout;

`ifdef SAR_CMP_TMO_EN
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;

    // Timeout fires on the CMP_TMO-th WAIT cycle after the comparator trigger
    assign timeout = (tmo_q == 8'(CMP_TMO - 1));

    // Timeout counter runs only in WAIT; sticky error set on expiry, cleared by an accepted START
    always_comb begin
        tmo_d = (state_q == S_WAIT) ? tmo_q + 8'd1 : 8'd0;
        err_d = err_q;
        if (state_q == S_IDLE && START) begin
            err_d = 1'b0;
        end else if (state_q == S_WAIT && !CMP_RDY && timeout) begin
            err_d = 1'b1;
        end
    end

    // Timeout counter and error flag registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign timeout = 1'b0;
    assign ERR     = 1'b0;
`endif

    // Next-state and next-output decode; every output is registered from these
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        sw_d     = sw_q;
        dout_d   = dout_q;
        smp_d    = 1'b0;
        cmp_en_d = 1'b0;
        dvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SAMPLE;
                    sw_d    = '0;
                    cnt_d   = 8'd0;
                    smp_d   = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == 8'(SAMPLE_CYC - 1)) begin
                    state_d        = S_TRIAL;
                    k_d            = KW'(NBIT - 1);
                    sw_d[NBIT-1]   = 1'b1;
                    cmp_en_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    smp_d = 1'b1;
                end
            end
            S_TRIAL: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A timeout resolves the bit as if the comparator said 0
                if (CMP_RDY || timeout) begin
                    sw_d[k_q] = CMP_RDY & CMP_OUT;
                    if (k_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d               = S_TRIAL;
                        k_d                   = k_q - KW'(1);
                        sw_d[k_q - KW'(1)]    = 1'b1;
                        cmp_en_d              = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                dout_d   = sw_q;
                dvalid_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            k_q      <= '0;
            sw_q     <= '0;
            dout_q   <= '0;
            smp_q    <= 1'b0;
            cmp_en_q <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            sw_q     <= sw_d;
            dout_q   <= dout_d;
            smp_q    <= smp_d;
            cmp_en_q <= cmp_en_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
        end
    end

    assign SMP    = smp_q;
    assign CMP_EN = cmp_en_q;
    assign SW     = sw_q;
    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_sar_cdac_ctrl.sv
// tb/tb_sar_cdac_ctrl.sv - self-checking bench for sar_cdac_ctrl
module tb_sar_cdac_ctrl;

    localparam int NBIT = 11;
    localparam int SC   = 4;
    localparam int TMO  = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic START = 1'b0;
    logic CMP_RDY = 1'b0;
    logic CMP_OUT = 1'b0;
    logic SMP, CMP_EN, DVALID, BUSY, ERR;
    logic [NBIT-1:0] SW, DOUT;

    sar_cdac_ctrl #(.NBIT(NBIT), .SAMPLE_CYC(SC), .CMP_TMO(TMO)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CMP_RDY(CMP_RDY), .CMP_OUT(CMP_OUT),
        .SMP(SMP), .CMP_EN(CMP_EN), .SW(SW), .DOUT(DOUT), .DVALID(DVALID),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Comparator model: ideal comparator of analog input vin, ready dly cycles after CMP_EN
    int vin = 0;
    int dly = 1;
    bit noise = 1'b0;
    bit withhold = 1'b0;
    bit kick = 1'b0;
    int wcnt = 0;

    initial forever begin
        @(posedge CLK);
        #1;
        CMP_RDY = 1'b0;
        CMP_OUT = 1'b0;
        if (RST) begin
            wcnt = 0;
        end else if (CMP_EN) begin
            wcnt = withhold ? 0 : dly;
            if (noise) begin CMP_RDY = 1'b1; CMP_OUT = 1'b1; end
        end else if (kick) begin
            kick = 1'b0;
            CMP_RDY = 1'b1;
            CMP_OUT = (int'(SW) <= vin);
        end else if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) begin
                CMP_RDY = 1'b1;
                CMP_OUT = (int'(SW) <= vin);
            end
        end else if (noise && SMP) begin
            CMP_RDY = 1'b1;
            CMP_OUT = 1'b1;
        end
    end

    typedef struct {
        int vin;
        int dly;
        bit noise;
        int exp_dout;
        int exp_lat;
    } vec_t;

    vec_t vt[7];

    task automatic pulse_start();
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
    endtask

    // One full conversion, checking latency, result, trial codes and output protocol
    task automatic convert(input vec_t v, input string tag);
        int cyc, nen, nsmp, bad_trial, bad_proto, k, lat, trial;
        bit prev_en;
        vin = v.vin; dly = v.dly; noise = v.noise;
        nen = 0; nsmp = 0; bad_trial = 0; bad_proto = 0; k = NBIT - 1; lat = -1; prev_en = 0;
        pulse_start();
        cyc = 1;
        while (cyc < 400) begin
            if (CMP_EN) begin
                nen++;
                if (k < 0) bad_trial++;
                else begin
                    trial = ((v.vin >> (k + 1)) << (k + 1)) | (1 << k);
                    if (int'(SW) != trial) bad_trial++;
                end
                k--;
                if (prev_en || SMP) bad_proto++;
            end
            if (SMP) nsmp++;
            if (ERR) bad_proto++;
            if (!BUSY && !DVALID) bad_proto++;
            prev_en = CMP_EN;
            if (DVALID) begin lat = cyc; break; end
            @(negedge CLK);
            cyc++;
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " dout"}, int'(DOUT), v.exp_dout);
        chk({tag, " cmp_en pulses"}, nen, NBIT);
        chk({tag, " smp cycles"}, nsmp, SC);
        chk({tag, " trial codes wrong"}, bad_trial, 0);
        chk({tag, " protocol errors"}, bad_proto, 0);
        @(negedge CLK);
        chk({tag, " sw held"}, int'(SW), v.exp_dout);
        chk({tag, " idle after done"}, {BUSY, DVALID}, 0);
        noise = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, ndv, cap;
        vt[0] = '{1234, 1, 1'b0, 1234, 28};
        vt[1] = '{0,    1, 1'b0, 0,    28};
        vt[2] = '{2047, 1, 1'b0, 2047, 28};
        vt[3] = '{1234, 5, 1'b0, 1234, 72};
        vt[4] = '{1,    2, 1'b0, 1,    39};
        vt[5] = '{1024, 1, 1'b1, 1024, 28};
        vt[6] = '{683,  3, 1'b0, 683,  50};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst sw", int'(SW), 0);
        chk("rst dout", int'(DOUT), 0);
        chk("rst smp/cmp_en", {SMP, CMP_EN}, 0);
        chk("rst dvalid", DVALID, 0);
        chk("rst busy", BUSY, 0);
        chk("rst err", ERR, 0);

        // Reset wins over START in the same cycle
        START = 1'b1;
        @(negedge CLK);
        chk("rst prio busy", BUSY, 0);
        chk("rst prio smp", SMP, 0);
        RST = 1'b0;
        START = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 7; i++) begin
            convert(vt[i], $sformatf("vec%0d", i));
        end

        // Reset on the third WAIT cycle of a conversion
        vin = 1234; dly = 1;
        pulse_start();
        n = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            if (CMP_EN) n++;
            if (n < 3) @(negedge CLK);
        end
        chk("reach third trial", n, 3);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mid rst sw", int'(SW), 0);
        chk("mid rst dout", int'(DOUT), 0);
        chk("mid rst flags", {SMP, CMP_EN, DVALID, BUSY, ERR}, 0);
        @(negedge CLK);
        convert(vt[0], "after_rst");

        // START pulsed during WAIT is ignored
        vin = 300; dly = 1;
        pulse_start();
        ndv = 0; cap = -1;
        for (int c = 1; c < 80; c++) begin
            if (c == 12) START = 1'b1;
            else START = 1'b0;
            if (DVALID) begin ndv++; cap = int'(DOUT); end
            @(negedge CLK);
        end
        START = 1'b0;
        chk("busy start dvalid count", ndv, 1);
        chk("busy start dout", cap, 300);
        chk("busy start idle", BUSY, 0);

        // Comparator never answers on the MSB
        vin = 1234; dly = 1; withhold = 1'b1;
        pulse_start();
        n = 0;
        for (int c = 0; c < 20 && !CMP_EN; c++) @(negedge CLK);
        chk("msb trigger", CMP_EN, 1);
        withhold = 1'b0;
`ifdef SAR_CMP_TMO_EN
        repeat (TMO) @(negedge CLK);
        chk("tmo err before expiry", ERR, 0);
        @(negedge CLK);
        chk("tmo err set", ERR, 1);
        chk("tmo msb cleared", int'(SW), 512);
        ndv = 0;
        for (int c = 0; c < 100 && !DVALID; c++) @(negedge CLK);
        chk("tmo dvalid", DVALID, 1);
        chk("tmo dout", int'(DOUT), 1023);
        chk("tmo err sticky", ERR, 1);
        @(negedge CLK);
        pulse_start();
        chk("tmo err cleared by start", ERR, 0);
        for (int c = 0; c < 100 && !DVALID; c++) @(negedge CLK);
        chk("tmo next dout", int'(DOUT), 1234);
        @(negedge CLK);
`else
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!BUSY || DVALID || ERR || int'(SW) != 1024) n++;
        end
        chk("wait holds without ready", n, 0);
        kick = 1'b1;
        for (int c = 0; c < 100 && !DVALID; c++) @(negedge CLK);
        chk("late ready dvalid", DVALID, 1);
        chk("late ready dout", int'(DOUT), 1234);
        chk("late ready err", ERR, 0);
        @(negedge CLK);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
